// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - opcode enum and multiplier FSM states shared by alu_mc and alu_mul_iter
package alu_mc_pkg;

   typedef enum logic [3:0] {
      kADD  = 4'h0,
      kSUB  = 4'h1,
      kAND  = 4'h2,
      kXOR  = 4'h3,
      kMOV  = 4'h4,
      kLSH  = 4'h5,
      kRSH  = 4'h6,
      kCOMP = 4'h7,
      kMUL  = 4'h8
   } op_mne;

   typedef enum logic {
      MUL_IDLE = 1'b0,
      MUL_RUN  = 1'b1
   } mul_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add unsigned multiplier, one product bit per cycle
module alu_mul_iter
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   mul_state_e         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [2*WIDTH-1:0] p_q, p_d;
   logic               done_q, done_d;
   logic [WIDTH:0]     sum;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= MUL_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         p_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         p_q     <= p_d;
         done_q  <= done_d;
      end
   end

   // Upper half accumulates; multiplier bits are consumed from the low end as the pair shifts right.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      p_d     = p_q;
      done_d  = 1'b0;
      sum     = '0;
      case (state_q)
         MUL_IDLE: begin
            if (start_i) begin
               a_d     = a_i;
               p_d     = {{WIDTH{1'b0}}, b_i};
               cnt_d   = '0;
               state_d = MUL_RUN;
            end
         end
         MUL_RUN: begin
            sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
            p_d   = {sum, p_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = MUL_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = MUL_IDLE;
      endcase
   end

   assign busy_o    = (state_q == MUL_RUN);
   assign done_o    = done_q;
   assign product_o = p_q;

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU; single-cycle ops plus kMUL via alu_mul_iter when ALU_MC_MUL_EN is defined
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH) + 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  op_mne            OP,
   input  logic [WIDTH-1:0] INPUTA,
   input  logic [WIDTH-1:0] INPUTB,
   input  logic             SC_IN,
   output logic [WIDTH-1:0] OUT,
   output logic [WIDTH-1:0] OUT_HI,
   output logic             SC_OUT,
   output logic             ZERO,
   output logic             GREATER,
   output logic             BUSY,
   output logic             DONE
);

   logic [WIDTH-1:0]   out_q, out_d, out_hi_q;
   logic               sc_q, sc_d, zero_q, zero_d, gt_q, gt_d, done_q;
   logic [WIDTH:0]     shl, shr;
   logic               accept;
   logic               mul_busy, mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   assign accept = START && !mul_busy;

`ifdef ALU_MC_MUL_EN
   localparam bit MUL_ON = 1'b1;

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk_i     (CLK),
      .reset_i   (RESET),
      .start_i   (accept && (OP == kMUL)),
      .a_i       (INPUTA),
      .b_i       (INPUTB),
      .busy_o    (mul_busy),
      .done_o    (mul_done),
      .product_o (mul_prod)
   );
`else
   localparam bit MUL_ON = 1'b0;

   assign mul_busy = 1'b0;
   assign mul_done = 1'b0;
   assign mul_prod = '0;
`endif

   // Guard bit above A (left) or below A (right) catches the last bit shifted out.
   assign shl = {1'b0, INPUTA} << INPUTB[SHW-1:0];
   assign shr = {INPUTA, 1'b0} >> INPUTB[SHW-1:0];

   always_comb begin
      out_d  = '0;
      sc_d   = 1'b0;
      zero_d = zero_q;
      gt_d   = gt_q;
      case (OP)
         kADD:    {sc_d, out_d} = {1'b0, INPUTA} + {1'b0, INPUTB} + {{WIDTH{1'b0}}, SC_IN};
         kSUB: begin
            out_d = INPUTA - INPUTB;
            sc_d  = (INPUTA < INPUTB);
         end
         kAND:    out_d = INPUTA & INPUTB;
         kXOR:    out_d = INPUTA ^ INPUTB;
         kMOV:    out_d = INPUTA;
         kLSH:    {sc_d, out_d} = shl;
         kRSH:    {out_d, sc_d} = shr;
         kCOMP: begin
            zero_d = (INPUTA == INPUTB);
            gt_d   = (INPUTA > INPUTB);
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         out_q    <= '0;
         out_hi_q <= '0;
         sc_q     <= 1'b0;
         zero_q   <= 1'b0;
         gt_q     <= 1'b0;
         done_q   <= 1'b0;
      end else if (accept && !(MUL_ON && (OP == kMUL))) begin
         out_q    <= out_d;
         out_hi_q <= '0;
         sc_q     <= sc_d;
         zero_q   <= zero_d;
         gt_q     <= gt_d;
         done_q   <= 1'b1;
      end else begin
         done_q <= 1'b0;
         // Keep the product visible after its DONE cycle.
         if (mul_done) begin
            out_q    <= mul_prod[WIDTH-1:0];
            out_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
            sc_q     <= 1'b0;
         end
      end
   end

   assign OUT     = mul_done ? mul_prod[WIDTH-1:0] : out_q;
   assign OUT_HI  = mul_done ? mul_prod[2*WIDTH-1:WIDTH] : out_hi_q;
   assign SC_OUT  = mul_done ? 1'b0 : sc_q;
   assign ZERO    = zero_q;
   assign GREATER = gt_q;
   assign BUSY    = mul_busy;
   assign DONE    = done_q | mul_done;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed self-checking bench for alu_mc (WIDTH=8); kMUL tests follow ALU_MC_MUL_EN
module tb_alu_mc;
   import alu_mc_pkg::*;

   localparam int W = 8;

   typedef struct {
      op_mne        op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] out;
      logic         sc;
   } vec_t;

   logic         CLK = 1'b0;
   logic         RESET, START, SC_IN;
   op_mne        OP;
   logic [W-1:0] INPUTA, INPUTB, OUT, OUT_HI;
   logic         SC_OUT, ZERO, GREATER, BUSY, DONE;

   int n_vec = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   alu_mc #(.WIDTH(W)) dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .START   (START),
      .OP      (OP),
      .INPUTA  (INPUTA),
      .INPUTB  (INPUTB),
      .SC_IN   (SC_IN),
      .OUT     (OUT),
      .OUT_HI  (OUT_HI),
      .SC_OUT  (SC_OUT),
      .ZERO    (ZERO),
      .GREATER (GREATER),
      .BUSY    (BUSY),
      .DONE    (DONE)
   );

   task automatic apply(input op_mne op, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      @(negedge CLK);
      START  = 1'b1;
      OP     = op;
      INPUTA = a;
      INPUTB = b;
      SC_IN  = cin;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      @(negedge CLK);
      START = 1'b0;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      n_vec++;
      if ({OUT, OUT_HI, SC_OUT, ZERO, GREATER, BUSY, DONE} !== '0) begin
         n_bad++;
         $display("FAIL reset_state: OUT=%h OUT_HI=%h SC=%b Z=%b G=%b BUSY=%b DONE=%b, want all 0",
                  OUT, OUT_HI, SC_OUT, ZERO, GREATER, BUSY, DONE);
      end
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   task automatic test_comp();
      logic [W-1:0] a [4] = '{8'h05, 8'h03, 8'h09, 8'h0F};
      logic [W-1:0] b [4] = '{8'h05, 8'h09, 8'h03, 8'h0F};
      logic         ez[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      logic         eg[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         apply((i == 3) ? kXOR : kCOMP, a[i], b[i], 1'b0);
         n_vec++;
         if ({ZERO, GREATER, OUT, DONE} !== {ez[i], eg[i], 8'h00, 1'b1}) begin
            n_bad++;
            $display("FAIL comp_%0d: Z=%b G=%b OUT=%h DONE=%b, want Z=%b G=%b OUT=00 DONE=1",
                     i, ZERO, GREATER, OUT, DONE, ez[i], eg[i]);
         end
      end
      idle();
   endtask

   task automatic test_add();
      apply(kADD, 8'hFF, 8'h01, 1'b1);
      n_vec++;
      if ({OUT, SC_OUT, DONE, ZERO, GREATER} !== {8'h01, 1'b1, 1'b1, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL add_carry: OUT=%h SC=%b DONE=%b Z=%b G=%b, want 01 1 1 0 1",
                  OUT, SC_OUT, DONE, ZERO, GREATER);
      end
      idle();
      n_vec++;
      if (DONE !== 1'b0) begin
         n_bad++;
         $display("FAIL done_pulse: DONE=%b, want 0", DONE);
      end
      apply(kADD, 8'h12, 8'h34, 1'b0);
      n_vec++;
      if ({OUT, SC_OUT} !== {8'h46, 1'b0}) begin
         n_bad++;
         $display("FAIL add_plain: OUT=%h SC=%b, want 46 0", OUT, SC_OUT);
      end
      apply(kADD, 8'h80, 8'h7F, 1'b1);
      n_vec++;
      if ({OUT, SC_OUT} !== {8'h00, 1'b1}) begin
         n_bad++;
         $display("FAIL add_wrap: OUT=%h SC=%b, want 00 1", OUT, SC_OUT);
      end
      idle();
   endtask

   task automatic test_vectors(input string name, input vec_t v[$]);
      foreach (v[i]) begin
         apply(v[i].op, v[i].a, v[i].b, v[i].cin);
         n_vec++;
         if ({OUT, SC_OUT, DONE, OUT_HI} !== {v[i].out, v[i].sc, 1'b1, 8'h00}) begin
            n_bad++;
            $display("FAIL %s_%0d: OUT=%h SC=%b DONE=%b OUT_HI=%h, want OUT=%h SC=%b DONE=1 OUT_HI=00",
                     name, i, OUT, SC_OUT, DONE, OUT_HI, v[i].out, v[i].sc);
         end
      end
      idle();
   endtask

   task automatic test_logic();
      vec_t v[$] = '{
         '{kSUB, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0},
         '{kSUB, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1},
         '{kAND, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0},
         '{kXOR, 8'hF0, 8'h3C, 1'b0, 8'hCC, 1'b0},
         '{kMOV, 8'h5A, 8'hA5, 1'b0, 8'h5A, 1'b0}
      };
      test_vectors("logic", v);
   endtask

   task automatic test_shift();
      vec_t v[$] = '{
         '{kLSH, 8'h81, 8'h01, 1'b0, 8'h02, 1'b1},
         '{kRSH, 8'h81, 8'h00, 1'b0, 8'h81, 1'b0},
         '{kRSH, 8'h81, 8'h09, 1'b0, 8'h00, 1'b0},
         '{kLSH, 8'h81, 8'h08, 1'b0, 8'h00, 1'b1},
         '{kLSH, 8'h81, 8'h00, 1'b0, 8'h81, 1'b0},
         '{kRSH, 8'h81, 8'h08, 1'b0, 8'h00, 1'b1},
         '{kLSH, 8'h81, 8'h09, 1'b0, 8'h00, 1'b0},
         '{kRSH, 8'h81, 8'h11, 1'b0, 8'h40, 1'b1},
         '{kLSH, 8'h35, 8'h03, 1'b0, 8'hA8, 1'b1},
         '{kRSH, 8'h35, 8'h03, 1'b0, 8'h06, 1'b1},
         '{kLSH, 8'hFF, 8'h0F, 1'b0, 8'h00, 1'b0}
      };
      test_vectors("shift", v);
   endtask

   task automatic test_back_to_back();
      vec_t v[$] = '{
         '{kADD, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0},
         '{kSUB, 8'h05, 8'h01, 1'b0, 8'h04, 1'b0},
         '{kXOR, 8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0}
      };
      test_vectors("b2b", v);
      n_vec++;
      if (DONE !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_idle: DONE=%b, want 0", DONE);
      end
   endtask

   task automatic test_nop();
      apply(kCOMP, 8'h05, 8'h05, 1'b0);
      apply(kADD, 8'hFF, 8'h01, 1'b1);
      apply(op_mne'(4'hF), 8'h03, 8'h04, 1'b1);
      n_vec++;
      if ({OUT, SC_OUT, DONE, ZERO, GREATER, OUT_HI} !== {8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00}) begin
         n_bad++;
         $display("FAIL nop: OUT=%h SC=%b DONE=%b Z=%b G=%b OUT_HI=%h, want 00 0 1 1 0 00",
                  OUT, SC_OUT, DONE, ZERO, GREATER, OUT_HI);
      end
      idle();
   endtask

`ifdef ALU_MC_MUL_EN
   task automatic test_mul();
      int busy_n = 0;
      int done_at = 0;
      apply(kADD, 8'hFF, 8'h01, 1'b1);
      apply(kMUL, 8'hFF, 8'hFF, 1'b0);
      if (BUSY === 1'b1) busy_n++;
      // A kADD request and operand churn during RUN must not disturb the product.
      @(negedge CLK);
      START  = 1'b1;
      OP     = kADD;
      INPUTA = 8'h01;
      INPUTB = 8'h01;
      for (int k = 1; k <= 12 && done_at == 0; k++) begin
         @(posedge CLK);
         #1;
         START  = 1'b0;
         OP     = kSUB;
         INPUTA = 8'h33;
         INPUTB = 8'h44;
         if (DONE === 1'b1) done_at = k;
         else if (BUSY === 1'b1) busy_n++;
      end
      n_vec++;
      if (busy_n != 8 || done_at != 8) begin
         n_bad++;
         $display("FAIL mul_timing: busy cycles=%0d done edge=%0d, want 8 and 8", busy_n, done_at);
      end
      n_vec++;
      if ({OUT_HI, OUT, SC_OUT, BUSY, ZERO} !== {8'hFE, 8'h01, 1'b0, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL mul_result: OUT_HI=%h OUT=%h SC=%b BUSY=%b Z=%b, want FE 01 0 0 1",
                  OUT_HI, OUT, SC_OUT, BUSY, ZERO);
      end
      START  = 1'b1;
      OP     = kADD;
      INPUTA = 8'h02;
      INPUTB = 8'h03;
      SC_IN  = 1'b0;
      @(posedge CLK);
      #1;
      n_vec++;
      if ({OUT, OUT_HI, DONE, BUSY} !== {8'h05, 8'h00, 1'b1, 1'b0}) begin
         n_bad++;
         $display("FAIL mul_start_on_done: OUT=%h OUT_HI=%h DONE=%b BUSY=%b, want 05 00 1 0",
                  OUT, OUT_HI, DONE, BUSY);
      end
      idle();
   endtask

   task automatic test_reset_abort();
      int seen = 0;
      apply(kMUL, 8'h12, 8'h34, 1'b0);
      @(negedge CLK);
      START = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      n_vec++;
      if ({OUT, OUT_HI, SC_OUT, ZERO, GREATER, BUSY, DONE} !== '0) begin
         n_bad++;
         $display("FAIL reset_abort: OUT=%h OUT_HI=%h SC=%b Z=%b G=%b BUSY=%b DONE=%b, want all 0",
                  OUT, OUT_HI, SC_OUT, ZERO, GREATER, BUSY, DONE);
      end
      @(negedge CLK);
      RESET = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge CLK);
         #1;
         if (DONE === 1'b1 || BUSY === 1'b1) seen++;
      end
      n_vec++;
      if (seen != 0) begin
         n_bad++;
         $display("FAIL abort_no_done: DONE/BUSY seen %0d cycles, want 0", seen);
      end
      apply(kSUB, 8'h00, 8'h01, 1'b0);
      n_vec++;
      if ({OUT, SC_OUT, DONE} !== {8'hFF, 1'b1, 1'b1}) begin
         n_bad++;
         $display("FAIL sub_after_abort: OUT=%h SC=%b DONE=%b, want FF 1 1", OUT, SC_OUT, DONE);
      end
      idle();
   endtask
`else
   task automatic test_mul_disabled();
      int busy_n = 0;
      apply(kADD, 8'hFF, 8'h01, 1'b1);
      apply(kMUL, 8'h03, 8'h04, 1'b0);
      n_vec++;
      if ({DONE, OUT, OUT_HI, SC_OUT, BUSY} !== {1'b1, 8'h00, 8'h00, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL mul_disabled: DONE=%b OUT=%h OUT_HI=%h SC=%b BUSY=%b, want 1 00 00 0 0",
                  DONE, OUT, OUT_HI, SC_OUT, BUSY);
      end
      idle();
      for (int k = 0; k < 4; k++) begin
         @(posedge CLK);
         #1;
         if (BUSY !== 1'b0) busy_n++;
      end
      n_vec++;
      if (busy_n != 0) begin
         n_bad++;
         $display("FAIL mul_disabled_busy: BUSY high %0d cycles, want 0", busy_n);
      end
   endtask
`endif

   task automatic test_reset_priority();
      apply(kCOMP, 8'h09, 8'h03, 1'b0);
      apply(kADD, 8'h7F, 8'h7F, 1'b1);
      @(negedge CLK);
      RESET  = 1'b1;
      START  = 1'b1;
      OP     = kADD;
      INPUTA = 8'h01;
      INPUTB = 8'h01;
      @(posedge CLK);
      #1;
      n_vec++;
      if ({OUT, OUT_HI, SC_OUT, ZERO, GREATER, BUSY, DONE} !== '0) begin
         n_bad++;
         $display("FAIL reset_priority: OUT=%h OUT_HI=%h SC=%b Z=%b G=%b BUSY=%b DONE=%b, want all 0",
                  OUT, OUT_HI, SC_OUT, ZERO, GREATER, BUSY, DONE);
      end
      @(negedge CLK);
      RESET = 1'b0;
      START = 1'b0;
   endtask

   initial begin
      RESET  = 1'b1;
      START  = 1'b0;
      OP     = kADD;
      INPUTA = '0;
      INPUTB = '0;
      SC_IN  = 1'b0;
      test_reset();
      test_comp();
      test_add();
      test_logic();
      test_shift();
      test_back_to_back();
      test_nop();
`ifdef ALU_MC_MUL_EN
      test_mul();
      test_reset_abort();
`else
      test_mul_disabled();
`endif
      test_reset_priority();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
